board_ctrl: RTL and testbench
=============================

// Module: board_ctrl
// PURPOSE
//  Owns the 4x4 game-board tile store and feeds the board display. Keeps a back
//  buffer that game logic writes and a front buffer that the display reads.
//  The back buffer is copied to the front buffer only during vertical blanking,
//  so a frame never shows a half-applied move. While copying, it also computes
//  the max-tile and empty-count statistics used for win/lose detection.
// PARAMETERS
//  V_ACTIVE  480  first cy value that counts as vertical blanking
//  N_TILES   16   tile count (4x4); index = {row,col}
//  EXP_W     5    tile exponent width; 0 = empty, e = 1..16 means value 2^e
//  DATA_W    17   width of the tile value sent to the display
// PORTS
//  CLK100MHZ   in   1       system clock (sole clock)
//  CPU_RESETN  in   1       reset, asynchronous, active-low
//  pix_stb     in   1       pixel strobe
//  cy          in   10      current scan line
//  disp_row    in   2       tile row under the beam
//  disp_col    in   2       tile column under the beam
//  disp_draw   in   1       beam is over the board area
//  disp_data   out  17      value of the tile under the beam (0 = empty)
//  wr_req      in   1       game write request; held until wr_ack
//  wr_addr     in   4       tile index {row,col}
//  wr_exp      in   5       exponent to write; values >16 clamp to 16
//  wr_ack      out  1       1-cycle pulse: write accepted
//  clr_req     in   1       pulse: clear the back buffer (new game)
//  commit_req  in   1       pulse: publish back buffer at next blanking
//  commit_done out  1       1-cycle pulse: copy finished, stats updated
//  busy        out  1       FSM not in IDLE
//  max_exp     out  5       largest exponent in the front buffer
//  empty_cnt   out  5       number of empty tiles in the front buffer (0..16)
// BEHAVIOUR
//  Reset: front/back all 0; disp_data=0, wr_ack=0, commit_done=0, busy=0,
//   max_exp=0, empty_cnt=16; state=IDLE; pend=0; idx=0. Reset fully aborts any
//   CLEAR/COPY in progress.
//  Display read path (independent of the FSM), registered, 1-cycle latency:
//   - pix_stb & disp_draw: disp_data <= exp2val(front[{disp_row,disp_col}]).
//   - pix_stb & !disp_draw: disp_data <= 0.
//   - Otherwise disp_data holds its value.
//  pend is set by commit_req in any state and cleared when COPY is entered.
//   A commit_req that arrives during COPY therefore queues one more commit.
//  FSM states: IDLE, CLEAR, COPY. busy = (state != IDLE).
//  IDLE priority is clr_req > commit start > write:
//   - clr_req -> CLEAR with idx=0.
//   - pend & (cy >= V_ACTIVE) -> COPY with idx=0 and pend cleared;
//     reset accumulators to max=0, empty=0.
//   - wr_req & !wr_ack -> back[wr_addr] <= clamp16(wr_exp); wr_ack=1 next cycle.
//     The !wr_ack gate makes a held request count as exactly one write.
//  CLEAR: back[idx] <= 0, idx++ each cycle. After idx 15 -> IDLE (16 cycles).
//   clr_req during CLEAR is ignored.
//  COPY: each cycle front[idx] <= back[idx], update max/empty from back[idx],
//   idx++. After idx 15: max_exp and empty_cnt take the final totals (including
//   entry 15), commit_done pulses, state -> IDLE. Copy takes 16 cycles.
//  Stalls: wr_req during CLEAR or COPY is not acked; it is accepted on the first
//   IDLE cycle unless a higher-priority event wins that cycle. A clr_req pulse
//   during COPY is lost; game logic only issues clear when !busy.
//  COPY is entered only in blanking. 16 cycles is far shorter than blanking, so
//   display reads never see a mixed front buffer.
//  Width rules: exp2val(0)=0; exp2val(e)=17'd1<<e for e in 1..16.
//   empty_cnt needs 5 bits to hold 16. max compare is unsigned.
// STRUCTURE
//  board_defs.vh: N_TILES, EXP_W, DATA_W, state encodings S_IDLE/S_CLEAR/S_COPY.
//  Sub-module exp2val: combinational exponent -> DATA_W decoder; also usable
//   elsewhere.
//  Storage: two 16 x EXP_W register arrays. FSM, idx counter and stat
//   accumulators live in board_ctrl.
// TESTING
//  1 Reset: drive CPU_RESETN=0 then release -> disp_data=0, empty_cnt=16,
//    max_exp=0, busy=0.
//  2 Write addr 5 with exp 3, commit, hold cy<480 for 100 cycles -> no copy,
//    busy=0. Set cy=480 -> busy for 16 cycles, then commit_done with
//    max_exp=3, empty_cnt=15. A pixel at row 1, col 1 with draw then gives
//    disp_data=8 one cycle later.
//  3 wr_exp=31 at addr 0, commit in blanking -> max_exp=16;
//    read of row 0, col 0 gives disp_data=65536.
//  4 Hold wr_req for 10 cycles -> exactly one wr_ack and one write.
//    Issue wr_req during CLEAR -> ack arrives only after the 16th clear cycle.
//  5 Fill all tiles, commit, clr_req, commit again -> empty_cnt=16, max_exp=0,
//    all disp_data reads 0.
//  6 Start COPY, assert commit_req at idx 7, and pull reset at idx 10 ->
//    all outputs return to reset values; front buffer all 0; no commit_done.

Source files
------------

// File: rtl/board_ctrl_pkg.sv
// Shared constants, FSM state encoding and tile helpers for the game-board store.
package board_ctrl_pkg;

   localparam int V_ACTIVE = 480;
   localparam int N_TILES  = 16;
   localparam int EXP_W    = 5;
   localparam int DATA_W   = 17;
   localparam int IDX_W    = 4;

   localparam logic [EXP_W-1:0] EXP_MAX = 5'd16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_COPY  = 2'd2
   } state_t;

   function automatic logic [EXP_W-1:0] clamp16(input logic [EXP_W-1:0] tile_exp);
      return (tile_exp > EXP_MAX) ? EXP_MAX : tile_exp;
   endfunction

endpackage

// File: rtl/board_ctrl_exp2val.sv
// Tile exponent to display value decoder: 0 -> 0 (empty), e -> 2^e.
module board_ctrl_exp2val
   import board_ctrl_pkg::*;
(
   input  logic [EXP_W-1:0]  tile_exp,
   output logic [DATA_W-1:0] value
);

   always_comb begin
      value = '0;
      if (tile_exp != '0 && tile_exp <= EXP_MAX)
         value = DATA_W'(1) << tile_exp;
   end

endmodule

// File: rtl/board_ctrl.sv
// 4x4 board tile store: back buffer written by game logic, front buffer read by
// the display, copied back-to-front during vertical blanking with win/lose stats.
module board_ctrl
   import board_ctrl_pkg::*;
(
   input  logic              CLK100MHZ,
   input  logic              CPU_RESETN,
   input  logic              pix_stb,
   input  logic [9:0]        cy,
   input  logic [1:0]        disp_row,
   input  logic [1:0]        disp_col,
   input  logic              disp_draw,
   output logic [DATA_W-1:0] disp_data,
   input  logic              wr_req,
   input  logic [IDX_W-1:0]  wr_addr,
   input  logic [EXP_W-1:0]  wr_exp,
   output logic              wr_ack,
   input  logic              clr_req,
   input  logic              commit_req,
   output logic              commit_done,
   output logic              busy,
   output logic [EXP_W-1:0]  max_exp,
   output logic [EXP_W-1:0]  empty_cnt
);

   logic [EXP_W-1:0] front [N_TILES];
   logic [EXP_W-1:0] back  [N_TILES];

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx;
   logic             pend;
   logic             wr_held;
   logic [EXP_W-1:0] acc_max, acc_empty;
   logic [EXP_W-1:0] max_nxt, empty_nxt;
   logic [EXP_W-1:0] copy_exp, disp_exp;
   logic [DATA_W-1:0] disp_val;
   logic             start_clear, start_copy, do_write, last_idx;

   assign busy     = (state != S_IDLE);
   assign last_idx = (idx == IDX_W'(N_TILES - 1));
   assign disp_exp = front[{disp_row, disp_col}];
   assign copy_exp = back[idx];
   assign max_nxt  = (copy_exp > acc_max) ? copy_exp : acc_max;
   assign empty_nxt = acc_empty + EXP_W'(copy_exp == '0);

   board_ctrl_exp2val u_exp2val (
      .tile_exp (disp_exp),
      .value    (disp_val)
   );

   // Display read path runs off the front buffer only, independent of the FSM.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN)
         disp_data <= '0;
      else if (pix_stb)
         disp_data <= disp_draw ? disp_val : '0;
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // NOTE: every signal driven here gets a default first, otherwise a latch is inferred.
   always_comb begin
      state_nxt   = state;
      start_clear = 1'b0;
      start_copy  = 1'b0;
      do_write    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (clr_req) begin
               start_clear = 1'b1;
               state_nxt   = S_CLEAR;
            end else if (pend && cy >= 10'(V_ACTIVE)) begin
               start_copy = 1'b1;
               state_nxt  = S_COPY;
            end else if (wr_req && !wr_ack && !wr_held) begin
               do_write = 1'b1;
            end
         end
         S_CLEAR, S_COPY: begin
            if (last_idx) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // wr_held keeps a request that stays high after its ack from writing twice;
   // it releases as soon as the requester drops wr_req.
   // NOTE: both tile arrays are reset because reset must leave an all-empty board.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         for (int i = 0; i < N_TILES; i++) begin
            front[i] <= '0;
            back[i]  <= '0;
         end
         idx         <= '0;
         pend        <= 1'b0;
         wr_held     <= 1'b0;
         wr_ack      <= 1'b0;
         commit_done <= 1'b0;
         acc_max     <= '0;
         acc_empty   <= '0;
         max_exp     <= '0;
         empty_cnt   <= EXP_W'(N_TILES);
      end else begin
         wr_ack      <= do_write;
         commit_done <= 1'b0;

         if (!wr_req)
            wr_held <= 1'b0;
         else if (do_write)
            wr_held <= 1'b1;

         if (commit_req)
            pend <= 1'b1;
         else if (start_copy)
            pend <= 1'b0;

         if (do_write)
            back[wr_addr] <= clamp16(wr_exp);

         if (start_clear || start_copy) begin
            idx       <= '0;
            acc_max   <= '0;
            acc_empty <= '0;
         end else if (state == S_CLEAR) begin
            back[idx] <= '0;
            idx       <= idx + 1'b1;
         end else if (state == S_COPY) begin
            front[idx] <= copy_exp;
            acc_max    <= max_nxt;
            acc_empty  <= empty_nxt;
            idx        <= idx + 1'b1;
            if (last_idx) begin
               max_exp     <= max_nxt;
               empty_cnt   <= empty_nxt;
               commit_done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_board_ctrl.sv
// Directed, table-driven bench for board_ctrl: writes, commits, clears and reset abort.
module tb_board_ctrl;

   logic        CLK100MHZ  = 1'b0;
   logic        CPU_RESETN = 1'b0;
   logic        pix_stb    = 1'b0;
   logic [9:0]  cy         = '0;
   logic [1:0]  disp_row   = '0;
   logic [1:0]  disp_col   = '0;
   logic        disp_draw  = 1'b0;
   logic [16:0] disp_data;
   logic        wr_req     = 1'b0;
   logic [3:0]  wr_addr    = '0;
   logic [4:0]  wr_exp     = '0;
   logic        wr_ack;
   logic        clr_req    = 1'b0;
   logic        commit_req = 1'b0;
   logic        commit_done;
   logic        busy;
   logic [4:0]  max_exp;
   logic [4:0]  empty_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0]  addr;
      logic [4:0]  tile_exp;
      logic [16:0] value;
   } vec_t;

   vec_t vecs [16];

   board_ctrl dut (
      .CLK100MHZ   (CLK100MHZ),
      .CPU_RESETN  (CPU_RESETN),
      .pix_stb     (pix_stb),
      .cy          (cy),
      .disp_row    (disp_row),
      .disp_col    (disp_col),
      .disp_draw   (disp_draw),
      .disp_data   (disp_data),
      .wr_req      (wr_req),
      .wr_addr     (wr_addr),
      .wr_exp      (wr_exp),
      .wr_ack      (wr_ack),
      .clr_req     (clr_req),
      .commit_req  (commit_req),
      .commit_done (commit_done),
      .busy        (busy),
      .max_exp     (max_exp),
      .empty_cnt   (empty_cnt)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK100MHZ);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic do_write(input logic [3:0] a, input logic [4:0] e);
      int n;
      wr_addr = a;
      wr_exp  = e;
      wr_req  = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!wr_ack && n < 40);
      check("write ack", 32'(wr_ack), 1);
      wr_req = 1'b0;
      tick();
   endtask

   task automatic do_commit(input string name, input logic [4:0] req_max, input logic [4:0] req_empty);
      int n;
      cy         = 10'd480;
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
      n = 0;
      while (!commit_done && n < 40) begin
         tick();
         n++;
      end
      check({name, " commit_done"}, 32'(commit_done), 1);
      check({name, " max_exp"}, 32'(max_exp), 32'(req_max));
      check({name, " empty_cnt"}, 32'(empty_cnt), 32'(req_empty));
      cy = '0;
      tick();
   endtask

   task automatic do_read(input string name, input logic [1:0] r, input logic [1:0] c,
                          input logic [16:0] req);
      disp_row  = r;
      disp_col  = c;
      pix_stb   = 1'b1;
      disp_draw = 1'b1;
      tick();
      pix_stb   = 1'b0;
      disp_draw = 1'b0;
      check(name, 32'(disp_data), 32'(req));
   endtask

   initial begin
      int n;
      int acks;
      int dones;
      logic seen;

      vecs[0]  = '{4'd0,  5'd1,  17'd2};
      vecs[1]  = '{4'd1,  5'd2,  17'd4};
      vecs[2]  = '{4'd2,  5'd3,  17'd8};
      vecs[3]  = '{4'd3,  5'd4,  17'd16};
      vecs[4]  = '{4'd4,  5'd5,  17'd32};
      vecs[5]  = '{4'd5,  5'd6,  17'd64};
      vecs[6]  = '{4'd6,  5'd7,  17'd128};
      vecs[7]  = '{4'd7,  5'd8,  17'd256};
      vecs[8]  = '{4'd8,  5'd9,  17'd512};
      vecs[9]  = '{4'd9,  5'd10, 17'd1024};
      vecs[10] = '{4'd10, 5'd11, 17'd2048};
      vecs[11] = '{4'd11, 5'd12, 17'd4096};
      vecs[12] = '{4'd12, 5'd13, 17'd8192};
      vecs[13] = '{4'd13, 5'd0,  17'd0};
      vecs[14] = '{4'd14, 5'd20, 17'd65536};
      vecs[15] = '{4'd15, 5'd16, 17'd65536};

      // Reset values, during and after reset.
      tick();
      tick();
      check("reset disp_data", 32'(disp_data), 0);
      check("reset empty_cnt", 32'(empty_cnt), 16);
      check("reset max_exp", 32'(max_exp), 0);
      check("reset busy", 32'(busy), 0);
      check("reset wr_ack", 32'(wr_ack), 0);
      check("reset commit_done", 32'(commit_done), 0);
      CPU_RESETN = 1'b1;
      tick();
      check("post-reset busy", 32'(busy), 0);
      check("post-reset empty_cnt", 32'(empty_cnt), 16);

      // Commit waits for blanking, then copies in 16 busy cycles.
      do_write(4'd5, 5'd3);
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         seen = seen | busy | commit_done;
      end
      check("no copy outside blanking", 32'(seen), 0);
      cy = 10'd480;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (commit_done) break;
         if (busy) n++;
      end
      check("copy busy cycles", n, 16);
      check("copy1 commit_done", 32'(commit_done), 1);
      check("copy1 max_exp", 32'(max_exp), 3);
      check("copy1 empty_cnt", 32'(empty_cnt), 15);
      cy = '0;
      tick();
      check("commit_done one cycle", 32'(commit_done), 0);
      do_read("read r1c1", 2'd1, 2'd1, 17'd8);

      // Exponent clamp.
      do_write(4'd0, 5'd31);
      do_commit("clamp", 5'd16, 5'd14);
      do_read("read r0c0 clamped", 2'd0, 2'd0, 17'd65536);

      // Held request counts as one write.
      wr_addr = 4'd2;
      wr_exp  = 5'd4;
      wr_req  = 1'b1;
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (wr_ack) acks++;
      end
      wr_req = 1'b0;
      tick();
      check("held write ack count", acks, 1);
      do_commit("held", 5'd16, 5'd13);
      do_read("read r0c2", 2'd0, 2'd2, 17'd16);

      // Write stalled by CLEAR is acked only after the 16 clear cycles.
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      check("busy in clear", 32'(busy), 1);
      wr_addr = 4'd15;
      wr_exp  = 5'd1;
      wr_req  = 1'b1;
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (wr_ack) begin
            n = i;
            break;
         end
      end
      check("ack delay after clear", n, 17);
      wr_req = 1'b0;
      tick();
      do_commit("after clear", 5'd1, 5'd15);
      do_read("read r3c3", 2'd3, 2'd3, 17'd2);

      // Full board from the vector table.
      for (int i = 0; i < 16; i++)
         do_write(vecs[i].addr, vecs[i].tile_exp);
      do_commit("full", 5'd16, 5'd1);
      for (int i = 0; i < 16; i++)
         do_read($sformatf("full read %0d", i), vecs[i].addr[3:2], vecs[i].addr[1:0], vecs[i].value);

      do_read("read before hold", 2'd0, 2'd0, 17'd2);
      disp_row = 2'd3;
      tick();
      check("disp_data holds without strobe", 32'(disp_data), 2);
      pix_stb   = 1'b1;
      disp_draw = 1'b0;
      tick();
      pix_stb = 1'b0;
      check("disp_data zero off board", 32'(disp_data), 0);

      // Clear, then a commit with a second one queued during COPY.
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      n = 0;
      while (busy && n < 40) begin
         tick();
         n++;
      end
      check("clear finished", 32'(busy), 0);
      cy = 10'd480;
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
      dones = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (commit_done) dones++;
      end
      check("queued commit count", dones, 2);
      check("cleared max_exp", 32'(max_exp), 0);
      check("cleared empty_cnt", 32'(empty_cnt), 16);
      cy = '0;
      for (int i = 0; i < 16; i++)
         do_read($sformatf("cleared read %0d", i), 2'(i >> 2), 2'(i), 17'd0);

      // Reset in the middle of COPY aborts everything.
      do_write(4'd3, 5'd5);
      cy = 10'd480;
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
      tick();
      for (int i = 0; i < 7; i++) tick();
      commit_req = 1'b1;
      disp_row   = 2'd0;
      disp_col   = 2'd3;
      pix_stb    = 1'b1;
      disp_draw  = 1'b1;
      tick();
      commit_req = 1'b0;
      pix_stb    = 1'b0;
      disp_draw  = 1'b0;
      check("mid-copy read", 32'(disp_data), 32);
      check("mid-copy busy", 32'(busy), 1);
      tick();
      tick();
      CPU_RESETN = 1'b0;
      #1;
      check("abort disp_data", 32'(disp_data), 0);
      check("abort busy", 32'(busy), 0);
      check("abort max_exp", 32'(max_exp), 0);
      check("abort empty_cnt", 32'(empty_cnt), 16);
      check("abort commit_done", 32'(commit_done), 0);
      tick();
      CPU_RESETN = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         seen = seen | busy | commit_done;
      end
      check("no commit after abort", 32'(seen), 0);
      cy = '0;
      do_read("abort front r0c3", 2'd0, 2'd3, 17'd0);
      do_commit("abort back", 5'd0, 5'd16);
      do_read("abort back r0c3", 2'd0, 2'd3, 17'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
